dcpu_int_queue: RTL and testbench
=================================

Name: dcpu_int_queue

Overview:
Parametrised interrupt queue and arbiter for the DCPU core. It collects software interrupts (INT instruction) and messages from NUM_SRC hardware devices into a FIFO of DEPTH entries, and presents them one at a time to the core at instruction boundaries. It honours IAQ queueing and IA==0 discard, and enters the "catch fire" state on queue overflow. It sits between the device bus and the core's fetch state machine and runs on the same CORE_CLK.

Parameters:
WIDTH, 16, message width in bits
DEPTH, 256, queue depth in entries; must be a power of 2, minimum 2
NUM_SRC, 4, number of hardware interrupt sources, 1..16

Ports:
CORE_CLK  in  1  core clock; all state updates on the rising edge
RESET  in  1  synchronous, active-high reset
hw_req  in  NUM_SRC  per-device request; held high until the matching hw_ack
hw_msg  in  NUM_SRC*WIDTH  per-device message; source i occupies bits [i*WIDTH +: WIDTH]
hw_ack  out  NUM_SRC  one-cycle pulse; source i's message was accepted this cycle
sw_valid  in  1  software interrupt request from the INT instruction
sw_msg  in  WIDTH  software interrupt message
sw_ready  out  1  software request accepted this cycle (valid & ready = transfer)
iaq  in  1  1 = queueing on; hold delivery
ia_zero  in  1  1 = core IA register is 0; delivered messages are discarded
int_valid  out  1  head message available to the core
int_msg  out  WIDTH  head message
int_ready  in  1  core takes the head this cycle
count  out  $clog2(DEPTH+1)  current number of queued entries
on_fire  out  1  sticky overflow flag
drop_cnt  out  16  discarded-message counter (see Optional Feature)

Behaviour:
- Reset (synchronous, while RESET=1): queue empty; count=0; int_valid=0; int_msg=0; hw_ack=0; sw_ready=0; on_fire=0; drop_cnt=0; state=RUN.
- States:
  - RUN: normal operation.
  - FIRE: entered on overflow. Only RESET leaves FIRE.
- Enqueue:
  - At most one push per cycle.
  - Priority: software first, then the lowest-index asserted hw_req.
  - sw_ready and hw_ack are combinational grants, asserted only in RUN. The granted message is written at that clock edge.
  - Losers stay pending; there are no partial acks.
- Dequeue, RUN only, at most one pop per cycle:
  - iaq=1: no pop; int_valid=0. The queue keeps filling.
  - iaq=0, ia_zero=0, count>0: int_valid=1 and int_msg=head (combinational from head storage). Pop when int_ready=1.
  - iaq=0, ia_zero=1, count>0: int_valid=0. The head is silently popped, one per cycle, until empty or until ia_zero or iaq changes.
  - int_ready while int_valid=0 is ignored.
- Latency: a message written at edge t is visible on int_msg in the cycle after t when the queue was empty. Minimum push-to-delivery is 1 cycle.
- count:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, and allowed at count=DEPTH
- Overflow: a grant would push while count=DEPTH and no pop occurs that cycle. Then:
  - the grant is suppressed (no ack, no write);
  - on_fire is set at the edge and the state moves to FIRE.
- FIRE: int_valid=0, sw_ready=0, hw_ack=0. Queue contents and count are frozen.
- Pointers: log2(DEPTH)-bit read and write pointers wrap modulo DEPTH. Full and empty are decided by count, not by pointer equality.
- Reset asserted mid-transfer: all pending grants and pops are dropped. The queue is empty on the next cycle.
- int_msg is held at its last value when int_valid=0. Only int_valid qualifies it.

Optional Feature:
Macro DCPU_INT_DROP_STATS_EN.
- Defined: drop_cnt is a 16-bit counter, saturating at 0xFFFF.
  - +1 per message discarded through the ia_zero path.
  - +1 per suppressed overflow push (counted once, on the cycle FIRE is entered).
  - Cleared by RESET.
- Undefined: drop_cnt is tied to 0, and no counter logic is generated.
- The port is present in both builds.

Test Plan:
- Reset, then sw_valid=1, sw_msg=0x1234, iaq=0, ia_zero=0 for 1 cycle: sw_ready=1 that cycle. The next cycle has int_valid=1, int_msg=0x1234, count=1. With int_ready=1 for one cycle: count=0, int_valid=0.
- sw_valid=1 (0xAAAA) and hw_req=4'b0110 (src1=0x0001, src2=0x0002) held, iaq=1: the queue order is 0xAAAA, 0x0001, 0x0002, with hw_ack pulsing src1 then src2 on consecutive cycles. Dropping iaq and holding int_ready=1 delivers the messages in that order.
- DEPTH=4, iaq=1, push 4 messages: count=4. A fifth hw_req: no hw_ack, on_fire=1 the next cycle, count stays 4, int_valid=0 even after iaq=0. Asserting RESET clears on_fire and sets count=0.
- DEPTH=4 full, iaq=0, ia_zero=0: int_ready=1 together with sw_valid=1 in the same cycle gives sw_ready=1, count stays 4, on_fire=0.
- 3 messages queued, iaq=0, ia_zero=1: count goes 3→2→1→0 over 3 cycles with int_valid=0 throughout. With DCPU_INT_DROP_STATS_EN defined, drop_cnt=3; without it, drop_cnt=0.
- DEPTH=4: 10 push/pop pairs with iaq=0 and int_ready=1 wrap the pointers. Messages 0..9 are delivered in order and count never exceeds 1.

Source files
------------

// File: rtl/dcpu_int_queue_if.sv
// rtl/dcpu_int_queue_if.sv - device, software and core handshake bundle for dcpu_int_queue
interface dcpu_int_queue_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]       hw_req;
    logic [NUM_SRC*WIDTH-1:0] hw_msg;
    logic [NUM_SRC-1:0]       hw_ack;
    logic                     sw_valid;
    logic [WIDTH-1:0]         sw_msg;
    logic                     sw_ready;
    logic                     int_valid;
    logic [WIDTH-1:0]         int_msg;
    logic                     int_ready;

    // System side: devices, INT instruction and the core fetch FSM
    modport master (
        output hw_req, hw_msg, sw_valid, sw_msg, int_ready,
        input  hw_ack, sw_ready, int_valid, int_msg
    );

    // Queue side
    modport slave (
        input  hw_req, hw_msg, sw_valid, sw_msg, int_ready,
        output hw_ack, sw_ready, int_valid, int_msg
    );
endinterface

// File: rtl/dcpu_int_queue.sv
// rtl/dcpu_int_queue.sv - DCPU interrupt queue/arbiter; optional drop counter under DCPU_INT_DROP_STATS_EN
module dcpu_int_queue #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 256,
    parameter int NUM_SRC = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH+1)
) (
    input  logic               CORE_CLK,
    input  logic               RESET,
    dcpu_int_queue_if.slave    bus,
    input  logic               iaq,
    input  logic               ia_zero,
    output logic [CNT_W-1:0]   count,
    output logic               on_fire,
    output logic [15:0]        drop_cnt
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {ST_RUN, ST_FIRE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [WIDTH-1:0]   last_msg;

    logic               run;
    logic               deliver;
    logic               discard;
    logic               pop;
    logic               want;
    logic               overflow;
    logic               grant;
    logic [NUM_SRC-1:0] hw_low;
    logic [WIDTH-1:0]   push_msg;

    // Arbitration, pop decision and overflow detection for this cycle
    always_comb begin
        run      = (state == ST_RUN) && !RESET;
        deliver  = run && !iaq && !ia_zero && (count != '0);
        discard  = run && !iaq &&  ia_zero && (count != '0);
        pop      = (deliver && bus.int_ready) || discard;
        want     = run && (bus.sw_valid || (bus.hw_req != '0));
        overflow = want && (count == FULL_CNT) && !pop;
        grant    = want && !overflow;
        hw_low   = bus.hw_req & (~bus.hw_req + NUM_SRC'(1));
        push_msg = bus.sw_msg;
        if (!bus.sw_valid) begin
            push_msg = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hw_low[i]) begin
                    push_msg = bus.hw_msg[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Software always beats devices; a device only sees its ack when software is idle
    assign bus.sw_ready  = grant && bus.sw_valid;
    assign bus.hw_ack    = (grant && !bus.sw_valid) ? hw_low : '0;
    assign bus.int_valid = deliver;
    assign bus.int_msg   = deliver ? mem[rd_ptr] : last_msg;

    // Queue storage, written only on a granted push
    always_ff @(posedge CORE_CLK) begin
        if (grant) begin
            mem[wr_ptr] <= push_msg;
        end
    end

    // Run/fire FSM with pointers, occupancy and the held output message
    always_ff @(posedge CORE_CLK) begin
        if (RESET) begin
            state    <= ST_RUN;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            on_fire  <= 1'b0;
            last_msg <= '0;
        end else begin
            last_msg <= bus.int_msg;
            if (grant) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (grant && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !grant) begin
                count <= count - CNT_W'(1);
            end
            case (state)
                ST_RUN: begin
                    if (overflow) begin
                        state   <= ST_FIRE;
                        on_fire <= 1'b1;
                    end
                end
                default: state <= ST_FIRE;
            endcase
        end
    end

`ifdef DCPU_INT_DROP_STATS_EN
    logic [15:0] drop_q;

    // Saturating count of ia_zero discards plus the single overflow that caused FIRE
    always_ff @(posedge CORE_CLK) begin
        if (RESET) begin
            drop_q <= '0;
        end else if ((discard || overflow) && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_dcpu_int_queue.sv
// tb/tb_dcpu_int_queue.sv - table, directed and random checks of dcpu_int_queue against a queue model
module tb_dcpu_int_queue;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int NUM_SRC = 4;
    localparam int CNT_W   = $clog2(DEPTH+1);
`ifdef DCPU_INT_DROP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             iaq;
    logic             ia_zero;
    logic [CNT_W-1:0] count;
    logic             on_fire;
    logic [15:0]      drop_cnt;

    dcpu_int_queue_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) bus();

    dcpu_int_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC)) dut (
        .CORE_CLK (clk),
        .RESET    (rst),
        .bus      (bus),
        .iaq      (iaq),
        .ia_zero  (ia_zero),
        .count    (count),
        .on_fire  (on_fire),
        .drop_cnt (drop_cnt)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Reference model: a plain queue of messages plus fire flag and drop tally
    logic [15:0] mq[$];
    bit          m_fire;
    int          m_drops;
    logic [15:0] m_last;
    bit          m_pop, m_disc, m_push, m_ovf;
    logic [15:0] m_msg;
    logic        e_sw_ready, e_int_valid;
    logic [3:0]  e_hw_ack;
    logic [15:0] e_int_msg;

    typedef struct {
        logic        rst;
        logic        sw_valid;
        logic [15:0] sw_msg;
        logic [3:0]  hw_req;
        logic        iaq;
        logic        ia_zero;
        logic        int_ready;
        logic        x_sw_ready;
        logic [3:0]  x_hw_ack;
        logic        x_int_valid;
        logic [15:0] x_int_msg;
        logic [2:0]  x_count;
    } vec_t;

    vec_t vt[13];
    logic [3:0]  rq;
    logic [15:0] rmsg[NUM_SRC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_eval();
        int depth_now;
        depth_now   = mq.size();
        e_sw_ready  = 1'b0;
        e_hw_ack    = 4'b0;
        e_int_valid = 1'b0;
        e_int_msg   = m_last;
        m_pop = 1'b0; m_disc = 1'b0; m_push = 1'b0; m_ovf = 1'b0; m_msg = 16'h0;
        if (!rst && !m_fire) begin
            if (!iaq && depth_now > 0) begin
                if (!ia_zero) begin
                    e_int_valid = 1'b1;
                    e_int_msg   = mq[0];
                    m_pop       = bus.int_ready;
                end else begin
                    m_pop  = 1'b1;
                    m_disc = 1'b1;
                end
            end
            if (bus.sw_valid || bus.hw_req != 4'b0) begin
                if (depth_now == DEPTH && !m_pop) begin
                    m_ovf = 1'b1;
                end else begin
                    m_push = 1'b1;
                    if (bus.sw_valid) begin
                        e_sw_ready = 1'b1;
                        m_msg      = bus.sw_msg;
                    end else begin
                        for (int i = NUM_SRC-1; i >= 0; i--) begin
                            if (bus.hw_req[i]) begin
                                e_hw_ack = 4'(1 << i);
                                m_msg    = bus.hw_msg[i*WIDTH +: WIDTH];
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_next();
        if (rst) begin
            mq.delete();
            m_fire = 1'b0; m_drops = 0; m_last = 16'h0;
        end else begin
            m_last = e_int_msg;
            if (m_pop) void'(mq.pop_front());
            if (m_disc) m_drops++;
            if (m_push) mq.push_back(m_msg);
            if (m_ovf) begin
                m_fire = 1'b1;
                m_drops++;
            end
        end
    endtask

    // One clock: compare every output to the model, advance the model, cross the edge
    task automatic cycle();
        int exp_drop;
        #3;
        model_eval();
        exp_drop = STATS ? ((m_drops > 65535) ? 65535 : m_drops) : 0;
        if (chk_en) begin
            check("sw_ready",  32'(bus.sw_ready),  32'(e_sw_ready));
            check("hw_ack",    32'(bus.hw_ack),    32'(e_hw_ack));
            check("int_valid", 32'(bus.int_valid), 32'(e_int_valid));
            check("int_msg",   32'(bus.int_msg),   32'(e_int_msg));
            check("count",     32'(count),         32'(mq.size()));
            check("on_fire",   32'(on_fire),       32'(m_fire));
            check("drop_cnt",  32'(drop_cnt),      32'(exp_drop));
        end
        model_next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_in(input logic sv, input logic [15:0] sm, input logic [3:0] hw,
                          input logic q, input logic z, input logic r);
        bus.sw_valid  = sv;
        bus.sw_msg    = sm;
        bus.hw_req    = hw;
        iaq           = q;
        ia_zero       = z;
        bus.int_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 16'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.hw_msg = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        set_in(1'b0, 16'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        chk_en = 1'b1;

        vt[0]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000, 3'd0};
        vt[1]  = '{1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h0000, 3'd0};
        vt[2]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h1234, 3'd1};
        vt[3]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'h1234, 3'd1};
        vt[4]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h1234, 3'd0};
        vt[5]  = '{1'b0, 1'b1, 16'hAAAA, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h1234, 3'd0};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 16'h1234, 3'd1};
        vt[7]  = '{1'b0, 1'b0, 16'h0000, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 16'h1234, 3'd2};
        vt[8]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h1234, 3'd3};
        vt[9]  = '{1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'hAAAA, 3'd3};
        vt[10] = '{1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'h0001, 3'd2};
        vt[11] = '{1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 16'h0002, 3'd1};
        vt[12] = '{1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0002, 3'd0};

        for (int i = 0; i < 13; i++) begin
            rst = vt[i].rst;
            set_in(vt[i].sw_valid, vt[i].sw_msg, vt[i].hw_req, vt[i].iaq, vt[i].ia_zero, vt[i].int_ready);
            #1;
            check("vec_sw_ready",  32'(bus.sw_ready),  32'(vt[i].x_sw_ready));
            check("vec_hw_ack",    32'(bus.hw_ack),    32'(vt[i].x_hw_ack));
            check("vec_int_valid", 32'(bus.int_valid), 32'(vt[i].x_int_valid));
            check("vec_int_msg",   32'(bus.int_msg),   32'(vt[i].x_int_msg));
            check("vec_count",     32'(count),         32'(vt[i].x_count));
            cycle();
        end

        // Overflow into FIRE, frozen until reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 16'(16'h0100 + k), 4'b0, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        check("ovf_full_count", 32'(count), 32'd4);
        set_in(1'b0, 16'h0, 4'b0001, 1'b1, 1'b0, 1'b0);
        #1;
        check("ovf_no_ack", 32'(bus.hw_ack), 32'd0);
        cycle();
        check("ovf_on_fire", 32'(on_fire), 32'd1);
        check("ovf_count_frozen", 32'(count), 32'd4);
        set_in(1'b1, 16'h0BAD, 4'b0001, 1'b0, 1'b0, 1'b1);
        #1;
        check("fire_int_valid", 32'(bus.int_valid), 32'd0);
        check("fire_sw_ready",  32'(bus.sw_ready),  32'd0);
        cycle();
        cycle();
        check("fire_count_held", 32'(count), 32'd4);
        do_reset();
        check("rst_on_fire", 32'(on_fire), 32'd0);
        check("rst_count",   32'(count),   32'd0);

        // Full queue: simultaneous pop and push is legal
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 16'(16'h0200 + k), 4'b0, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b1, 16'h02FF, 4'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("full_pp_sw_ready", 32'(bus.sw_ready), 32'd1);
        check("full_pp_head",     32'(bus.int_msg),  32'h0200);
        cycle();
        check("full_pp_count",   32'(count),   32'd4);
        check("full_pp_no_fire", 32'(on_fire), 32'd0);
        set_in(1'b0, 16'h0, 4'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cycle();
        check("full_pp_drained", 32'(count), 32'd0);

        // ia_zero discard path
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 16'(16'h0300 + k), 4'b0, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b0, 16'h0, 4'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("disc_int_valid", 32'(bus.int_valid), 32'd0);
            check("disc_count",     32'(count),         32'(3 - k));
            cycle();
        end
        check("disc_empty", 32'(count), 32'd0);
        check("disc_drop_cnt", 32'(drop_cnt), STATS ? 32'd3 : 32'd0);

        // Pointer wrap with back-to-back push/pop
        set_in(1'b0, 16'h0, 4'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            set_in(k < 10, 16'(k), 4'b0, 1'b0, 1'b0, 1'b1);
            #1;
            if (k > 0) begin
                check("wrap_valid", 32'(bus.int_valid), 32'd1);
                check("wrap_msg",   32'(bus.int_msg),   32'(k - 1));
            end
            cycle();
            check("wrap_count_le1", 32'(count <= 1), 32'd1);
        end

        // Random traffic against the model; devices hold requests until acked
        do_reset();
        rq = 4'b0;
        for (int i = 0; i < NUM_SRC; i++) rmsg[i] = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!rq[i] && $urandom_range(0, 2) == 0) begin
                    rq[i]   = 1'b1;
                    rmsg[i] = 16'($urandom);
                end
            end
            bus.hw_msg = {rmsg[3], rmsg[2], rmsg[1], rmsg[0]};
            set_in($urandom_range(0, 3) == 0, 16'($urandom), rq,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) != 0);
            cycle();
            rq = rq & ~e_hw_ack;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
